// File: rtl/sc_anim_sequencer_if.sv
// rtl/sc_anim_sequencer_if.sv - tick/request/render signal bundle for sc_anim_sequencer
interface sc_anim_sequencer_if #(
  parameter int FRAME_WIDTH = 2
);
  logic                   SC_ANIMSEQ_tick_InLow;
  logic                   SC_ANIMSEQ_moveReq_In;
  logic [1:0]             SC_ANIMSEQ_dir_InBUS;
  logic                   SC_ANIMSEQ_pause_In;
  logic [FRAME_WIDTH-1:0] SC_ANIMSEQ_frame_OutBUS;
  logic [1:0]             SC_ANIMSEQ_dir_OutBUS;
  logic                   SC_ANIMSEQ_busy_Out;
  logic                   SC_ANIMSEQ_done_OutPulse;
  logic                   SC_ANIMSEQ_step_OutPulse;

  // Driver side: speed comparator / game controller / render consumer
  modport master (
    output SC_ANIMSEQ_tick_InLow, SC_ANIMSEQ_moveReq_In, SC_ANIMSEQ_dir_InBUS, SC_ANIMSEQ_pause_In,
    input  SC_ANIMSEQ_frame_OutBUS, SC_ANIMSEQ_dir_OutBUS, SC_ANIMSEQ_busy_Out,
           SC_ANIMSEQ_done_OutPulse, SC_ANIMSEQ_step_OutPulse
  );

  // Sequencer side
  modport slave (
    input  SC_ANIMSEQ_tick_InLow, SC_ANIMSEQ_moveReq_In, SC_ANIMSEQ_dir_InBUS, SC_ANIMSEQ_pause_In,
    output SC_ANIMSEQ_frame_OutBUS, SC_ANIMSEQ_dir_OutBUS, SC_ANIMSEQ_busy_Out,
           SC_ANIMSEQ_done_OutPulse, SC_ANIMSEQ_step_OutPulse
  );
endinterface

// File: rtl/sc_anim_sequencer.sv
// rtl/sc_anim_sequencer.sv - frog hop frame sequencer; optional one-deep request buffer via SC_ANIMSEQ_QUEUE_EN
module sc_anim_sequencer #(
  parameter int FRAMES_PER_MOVE = 4,
  parameter int FRAME_WIDTH     = 2
) (
  input  logic                 SC_ANIMSEQ_CLOCK_50,
  input  logic                 SC_ANIMSEQ_RESET_InLow,
  sc_anim_sequencer_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    ANIMATE = 2'd2,
    DONE    = 2'd3
  } stateT;

  localparam logic [FRAME_WIDTH-1:0] LAST_FRAME = FRAME_WIDTH'(FRAMES_PER_MOVE - 1);

  stateT                  state, stateNext;
  logic [FRAME_WIDTH-1:0] frameQ, frameNext;
  logic [1:0]             dirQ, dirNext;
  logic                   busyQ, busyNext;
  logic                   doneQ, doneNext;
  logic                   stepQ, stepNext;
  logic                   tickPrev;
  logic                   strobe;

`ifdef SC_ANIMSEQ_QUEUE_EN
  logic                   qValid, qValidNext;
  logic [1:0]             qDir, qDirNext;
`endif

  // Falling edge of the active-low tick, dropped entirely while paused
  assign strobe = ~bus.SC_ANIMSEQ_tick_InLow & tickPrev & ~bus.SC_ANIMSEQ_pause_In;

  // State and registered outputs; reset aborts any hop without a done pulse
  always_ff @(posedge SC_ANIMSEQ_CLOCK_50 or negedge SC_ANIMSEQ_RESET_InLow) begin
    if (!SC_ANIMSEQ_RESET_InLow) begin
      state    <= IDLE;
      frameQ   <= '0;
      dirQ     <= 2'b00;
      busyQ    <= 1'b0;
      doneQ    <= 1'b0;
      stepQ    <= 1'b0;
      tickPrev <= 1'b1;
`ifdef SC_ANIMSEQ_QUEUE_EN
      qValid   <= 1'b0;
      qDir     <= 2'b00;
`endif
    end else begin
      state    <= stateNext;
      frameQ   <= frameNext;
      dirQ     <= dirNext;
      busyQ    <= busyNext;
      doneQ    <= doneNext;
      stepQ    <= stepNext;
      tickPrev <= bus.SC_ANIMSEQ_tick_InLow;
`ifdef SC_ANIMSEQ_QUEUE_EN
      qValid   <= qValidNext;
      qDir     <= qDirNext;
`endif
    end
  end

  // Hop sequencing: accept, wait for first strobe, count frames, pulse done/step
  always_comb begin
    stateNext = state;
    frameNext = frameQ;
    dirNext   = dirQ;
    busyNext  = busyQ;
    doneNext  = 1'b0;
    stepNext  = 1'b0;
`ifdef SC_ANIMSEQ_QUEUE_EN
    qValidNext = qValid;
    qDirNext   = qDir;
`endif
    case (state)
      IDLE: begin
        frameNext = '0;
        busyNext  = 1'b0;
        // The strobe in the acceptance cycle is ignored: ARM waits for a fresh one
        if (bus.SC_ANIMSEQ_moveReq_In) begin
          dirNext   = bus.SC_ANIMSEQ_dir_InBUS;
          busyNext  = 1'b1;
          stateNext = ARM;
        end
      end
      ARM: begin
        if (strobe) begin
          frameNext = FRAME_WIDTH'(1);
          stateNext = ANIMATE;
        end
      end
      ANIMATE: begin
        if (strobe) begin
          if (frameQ == LAST_FRAME) begin
            frameNext = '0;
            doneNext  = 1'b1;
            stepNext  = 1'b1;
            busyNext  = 1'b0;
            stateNext = DONE;
          end else begin
            frameNext = frameQ + FRAME_WIDTH'(1);
          end
        end
      end
      DONE: begin
        busyNext  = 1'b0;
        stateNext = IDLE;
`ifdef SC_ANIMSEQ_QUEUE_EN
        // A buffered request replaces the IDLE acceptance edge
        if (qValid) begin
          dirNext    = qDir;
          busyNext   = 1'b1;
          stateNext  = ARM;
          qValidNext = 1'b0;
        end else if (bus.SC_ANIMSEQ_moveReq_In) begin
          dirNext   = bus.SC_ANIMSEQ_dir_InBUS;
          busyNext  = 1'b1;
          stateNext = ARM;
        end
`endif
      end
      default: stateNext = IDLE;
    endcase
`ifdef SC_ANIMSEQ_QUEUE_EN
    // Capture one request mid-hop; later ones are dropped while the slot is full
    if (bus.SC_ANIMSEQ_moveReq_In && !qValid && (state == ARM || state == ANIMATE)) begin
      qValidNext = 1'b1;
      qDirNext   = bus.SC_ANIMSEQ_dir_InBUS;
    end
`endif
  end

  assign bus.SC_ANIMSEQ_frame_OutBUS  = frameQ;
  assign bus.SC_ANIMSEQ_dir_OutBUS    = dirQ;
  assign bus.SC_ANIMSEQ_busy_Out      = busyQ;
  assign bus.SC_ANIMSEQ_done_OutPulse = doneQ;
  assign bus.SC_ANIMSEQ_step_OutPulse = stepQ;

endmodule

// File: tb/tb_sc_anim_sequencer.sv
// tb/tb_sc_anim_sequencer.sv - self-checking bench for sc_anim_sequencer
module tb_sc_anim_sequencer;

  logic clk;
  logic rstN;
  int   checks;
  int   failures;
  string phase;

  sc_anim_sequencer_if #(.FRAME_WIDTH(2)) bus ();

  sc_anim_sequencer #(.FRAMES_PER_MOVE(4), .FRAME_WIDTH(2)) dut (
    .SC_ANIMSEQ_CLOCK_50    (clk),
    .SC_ANIMSEQ_RESET_InLow (rstN),
    .bus                    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] frame;
    logic [1:0] dir;
    logic       busy;
    logic       done;
    logic       step;
  } expT;

  typedef struct {
    logic [1:0] dir;
    int         gap;
    logic [1:0] expDir;
  } vecT;

  expT sb[$];
  vecT vecs[4];

  task automatic checkNow(input expT e);
    checks++;
    if (bus.SC_ANIMSEQ_frame_OutBUS !== e.frame || bus.SC_ANIMSEQ_dir_OutBUS !== e.dir ||
        bus.SC_ANIMSEQ_busy_Out !== e.busy || bus.SC_ANIMSEQ_done_OutPulse !== e.done ||
        bus.SC_ANIMSEQ_step_OutPulse !== e.step) begin
      failures++;
      $display("FAIL %s t=%0t got frame=%0d dir=%0d busy=%0b done=%0b step=%0b want frame=%0d dir=%0d busy=%0b done=%0b step=%0b",
               phase, $time, bus.SC_ANIMSEQ_frame_OutBUS, bus.SC_ANIMSEQ_dir_OutBUS, bus.SC_ANIMSEQ_busy_Out,
               bus.SC_ANIMSEQ_done_OutPulse, bus.SC_ANIMSEQ_step_OutPulse, e.frame, e.dir, e.busy, e.done, e.step);
    end
  endtask

  // Drive one cycle of inputs, queue the expected post-edge outputs, then compare after the edge
  task automatic cyc(input logic t, input logic m, input logic [1:0] d, input logic p,
                     input logic [1:0] eF, input logic [1:0] eD, input logic eB, input logic eDn);
    expT e;
    bus.SC_ANIMSEQ_tick_InLow = t;
    bus.SC_ANIMSEQ_moveReq_In = m;
    bus.SC_ANIMSEQ_dir_InBUS  = d;
    bus.SC_ANIMSEQ_pause_In   = p;
    e.frame = eF; e.dir = eD; e.busy = eB; e.done = eDn; e.step = eDn;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() > 0) checkNow(sb.pop_front());
  endtask

  initial begin
    expT e;
    logic [1:0] curF;
    logic [1:0] nxtF;
    checks   = 0;
    failures = 0;

    vecs[0] = '{dir: 2'b10, gap: 8, expDir: 2'b10};
    vecs[1] = '{dir: 2'b00, gap: 3, expDir: 2'b00};
    vecs[2] = '{dir: 2'b11, gap: 2, expDir: 2'b11};
    vecs[3] = '{dir: 2'b01, gap: 5, expDir: 2'b01};

    bus.SC_ANIMSEQ_tick_InLow = 1'b1;
    bus.SC_ANIMSEQ_moveReq_In = 1'b0;
    bus.SC_ANIMSEQ_dir_InBUS  = 2'b00;
    bus.SC_ANIMSEQ_pause_In   = 1'b0;
    rstN = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    phase = "reset";
    e = '{frame: 2'd0, dir: 2'b00, busy: 1'b0, done: 1'b0, step: 1'b0};
    checkNow(e);
    rstN = 1'b1;
    cyc(1, 0, 2'b11, 0, 0, 2'b00, 0, 0);

    // Table-driven hops: frame 1,2,3 then 0 with done/step on the 4th strobe; dir input toggled mid-hop
    for (int i = 0; i < 4; i++) begin
      $sformat(phase, "hop%0d", i);
      cyc(1, 1, vecs[i].dir, 0, 0, vecs[i].expDir, 1, 0);
      curF = 2'd0;
      for (int k = 0; k < 4; k++) begin
        nxtF = 2'(k + 1);
        for (int g = 0; g < vecs[i].gap - 1; g++)
          cyc(1, 0, vecs[i].dir ^ 2'b11, 0, curF, vecs[i].expDir, 1, 0);
        cyc(0, 0, vecs[i].dir ^ 2'b01, 0, nxtF, vecs[i].expDir, (k < 3), (k == 3));
        curF = nxtF;
      end
      cyc(1, 0, 2'b00, 0, 0, vecs[i].expDir, 0, 0);
      cyc(1, 0, 2'b00, 0, 0, vecs[i].expDir, 0, 0);
    end

    // Held tick: five low cycles produce one strobe
    phase = "held";
    cyc(1, 1, 2'b01, 0, 0, 2'b01, 1, 0);
    cyc(1, 0, 2'b01, 0, 0, 2'b01, 1, 0);
    cyc(0, 0, 2'b01, 0, 1, 2'b01, 1, 0);
    cyc(1, 0, 2'b01, 0, 1, 2'b01, 1, 0);
    cyc(0, 0, 2'b01, 0, 2, 2'b01, 1, 0);
    for (int k = 0; k < 4; k++) cyc(0, 0, 2'b01, 0, 2, 2'b01, 1, 0);
    cyc(1, 0, 2'b01, 0, 2, 2'b01, 1, 0);
    cyc(0, 0, 2'b01, 0, 3, 2'b01, 1, 0);
    cyc(1, 0, 2'b01, 0, 3, 2'b01, 1, 0);
    cyc(0, 0, 2'b01, 0, 0, 2'b01, 0, 1);
    cyc(1, 0, 2'b01, 0, 0, 2'b01, 0, 0);

    // Pause: acceptance still works, two paused ticks are lost
    phase = "pause";
    cyc(1, 1, 2'b00, 1, 0, 2'b00, 1, 0);
    cyc(0, 0, 2'b00, 0, 1, 2'b00, 1, 0);
    cyc(1, 0, 2'b00, 1, 1, 2'b00, 1, 0);
    cyc(0, 0, 2'b00, 1, 1, 2'b00, 1, 0);
    cyc(1, 0, 2'b00, 1, 1, 2'b00, 1, 0);
    cyc(0, 0, 2'b00, 1, 1, 2'b00, 1, 0);
    cyc(1, 0, 2'b00, 0, 1, 2'b00, 1, 0);
    cyc(0, 0, 2'b00, 0, 2, 2'b00, 1, 0);
    cyc(1, 0, 2'b00, 0, 2, 2'b00, 1, 0);
    cyc(0, 0, 2'b00, 0, 3, 2'b00, 1, 0);
    cyc(1, 0, 2'b00, 0, 3, 2'b00, 1, 0);
    cyc(0, 0, 2'b00, 0, 0, 2'b00, 0, 1);
    cyc(1, 0, 2'b00, 0, 0, 2'b00, 0, 0);

    // Coincident request and strobe: the strobe does not count
    phase = "coincident";
    cyc(0, 1, 2'b11, 0, 0, 2'b11, 1, 0);
    cyc(1, 0, 2'b11, 0, 0, 2'b11, 1, 0);
    cyc(0, 0, 2'b11, 0, 1, 2'b11, 1, 0);
    cyc(1, 0, 2'b11, 0, 1, 2'b11, 1, 0);
    cyc(0, 0, 2'b11, 0, 2, 2'b11, 1, 0);
    cyc(1, 0, 2'b11, 0, 2, 2'b11, 1, 0);
    cyc(0, 0, 2'b11, 0, 3, 2'b11, 1, 0);
    cyc(1, 0, 2'b11, 0, 3, 2'b11, 1, 0);
    cyc(0, 0, 2'b11, 0, 0, 2'b11, 0, 1);
    cyc(1, 0, 2'b11, 0, 0, 2'b11, 0, 0);

    // Busy request at frame 2 (dir 11), third request at frame 3 (dir 00)
    phase = "busyreq";
    cyc(1, 1, 2'b10, 0, 0, 2'b10, 1, 0);
    cyc(0, 0, 2'b10, 0, 1, 2'b10, 1, 0);
    cyc(1, 0, 2'b10, 0, 1, 2'b10, 1, 0);
    cyc(0, 0, 2'b10, 0, 2, 2'b10, 1, 0);
    cyc(1, 1, 2'b11, 0, 2, 2'b10, 1, 0);
    cyc(0, 0, 2'b10, 0, 3, 2'b10, 1, 0);
    cyc(1, 1, 2'b00, 0, 3, 2'b10, 1, 0);
    cyc(0, 0, 2'b10, 0, 0, 2'b10, 0, 1);
`ifdef SC_ANIMSEQ_QUEUE_EN
    cyc(1, 0, 2'b10, 0, 0, 2'b11, 1, 0);
    cyc(0, 0, 2'b10, 0, 1, 2'b11, 1, 0);
    cyc(1, 0, 2'b10, 0, 1, 2'b11, 1, 0);
    cyc(0, 0, 2'b10, 0, 2, 2'b11, 1, 0);
    cyc(1, 0, 2'b10, 0, 2, 2'b11, 1, 0);
    cyc(0, 0, 2'b10, 0, 3, 2'b11, 1, 0);
    cyc(1, 0, 2'b10, 0, 3, 2'b11, 1, 0);
    cyc(0, 0, 2'b10, 0, 0, 2'b11, 0, 1);
    cyc(1, 0, 2'b10, 0, 0, 2'b11, 0, 0);
    cyc(1, 0, 2'b10, 0, 0, 2'b11, 0, 0);
`else
    cyc(1, 0, 2'b10, 0, 0, 2'b10, 0, 0);
    cyc(0, 0, 2'b10, 0, 0, 2'b10, 0, 0);
    cyc(1, 0, 2'b10, 0, 0, 2'b10, 0, 0);
`endif

    // Asynchronous reset in ANIMATE at frame 2: immediate clear, no done pulse afterwards
    phase = "midreset";
    cyc(1, 1, 2'b11, 0, 0, 2'b11, 1, 0);
    cyc(0, 0, 2'b11, 0, 1, 2'b11, 1, 0);
    cyc(1, 0, 2'b11, 0, 1, 2'b11, 1, 0);
    cyc(0, 0, 2'b11, 0, 2, 2'b11, 1, 0);
    bus.SC_ANIMSEQ_tick_InLow = 1'b1;
    #2;
    rstN = 1'b0;
    #1;
    e = '{frame: 2'd0, dir: 2'b00, busy: 1'b0, done: 1'b0, step: 1'b0};
    checkNow(e);
    @(posedge clk);
    #1;
    rstN = 1'b1;
    phase = "postreset";
    for (int k = 0; k < 3; k++) begin
      cyc(1, 0, 2'b11, 0, 0, 2'b00, 0, 0);
      cyc(0, 0, 2'b11, 0, 0, 2'b00, 0, 0);
    end

    phase = "scoreboard";
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL %s leftover=%0d want 0", phase, sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
